// File: rtl/hex_entry_ctrl.sv
// Push-button hex entry: debounces four buttons, edits a 16-bit word one nibble
// at a time with a blinking cursor digit, and commits it with a one-cycle strobe.
module hex_entry_ctrl #(
   parameter int unsigned DEB_CYCLES = 32'd1000000,
   parameter int unsigned BLINK_BIT  = 24
) (
   input  logic        CLK,
   input  logic        Reset,
   input  logic        BTN_INC,
   input  logic        BTN_NEXT,
   input  logic        BTN_OK,
   input  logic        BTN_CLR,
   output logic [15:0] Edit,
   output logic [1:0]  Cursor,
   output logic [3:0]  Blank,
   output logic [15:0] Value,
   output logic        Valid
);

   localparam int unsigned BTN_INC_I  = 0;
   localparam int unsigned BTN_NEXT_I = 1;
   localparam int unsigned BTN_OK_I   = 2;
   localparam int unsigned BTN_CLR_I  = 3;
   localparam logic [31:0] DEB_LAST   = 32'(DEB_CYCLES - 1);

   logic [3:0]  btn_raw;
   logic [3:0]  s1_q, s2_q;
   logic [3:0]  stable_q, stable_d;
   logic [3:0]  stable_dly_q;
   logic [3:0]  ev_q, ev_d;
   logic [31:0] cnt_q [4];
   logic [31:0] cnt_d [4];

   logic [15:0] edit_q, edit_d;
   logic [15:0] value_q, value_d;
   logic [1:0]  cursor_q, cursor_d;
   logic        valid_q, valid_d;
   logic [31:0] blink_q, blink_d;
   logic [3:0]  blank;

   assign btn_raw = {BTN_CLR, BTN_OK, BTN_NEXT, BTN_INC};

   // A level is accepted only after DEB_CYCLES consecutive samples that differ
   // from the current stable level; any return to the stable level restarts it.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         stable_d[i] = stable_q[i];
         cnt_d[i]    = '0;
         if (s2_q[i] != stable_q[i]) begin
            if (cnt_q[i] == DEB_LAST) begin
               stable_d[i] = s2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 32'd1;
            end
         end
      end
      ev_d = stable_q & ~stable_dly_q;
   end

   // Fixed priority CLR > OK > INC > NEXT; losing events are simply dropped.
   always_comb begin
      edit_d   = edit_q;
      cursor_d = cursor_q;
      value_d  = value_q;
      valid_d  = 1'b0;
      blink_d  = blink_q + 32'd1;
      if (ev_q != 4'b0000) begin
         blink_d = '0;
      end
      if (ev_q[BTN_CLR_I]) begin
         edit_d   = '0;
         cursor_d = '0;
      end else if (ev_q[BTN_OK_I]) begin
         value_d = edit_q;
         valid_d = 1'b1;
      end else if (ev_q[BTN_INC_I]) begin
         edit_d[{cursor_q, 2'b00} +: 4] = edit_q[{cursor_q, 2'b00} +: 4] + 4'd1;
      end else if (ev_q[BTN_NEXT_I]) begin
         cursor_d = cursor_q + 2'd1;
      end
   end

   always_comb begin
      blank           = '0;
      blank[cursor_q] = blink_q[BLINK_BIT];
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         s1_q         <= '0;
         s2_q         <= '0;
         stable_q     <= '0;
         stable_dly_q <= '0;
         ev_q         <= '0;
         for (int i = 0; i < 4; i++) begin
            cnt_q[i] <= '0;
         end
         edit_q       <= '0;
         value_q      <= '0;
         cursor_q     <= '0;
         valid_q      <= 1'b0;
         blink_q      <= '0;
      end else begin
         s1_q         <= btn_raw;
         s2_q         <= s1_q;
         stable_q     <= stable_d;
         stable_dly_q <= stable_q;
         ev_q         <= ev_d;
         for (int i = 0; i < 4; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
         edit_q       <= edit_d;
         value_q      <= value_d;
         cursor_q     <= cursor_d;
         valid_q      <= valid_d;
         blink_q      <= blink_d;
      end
   end

   assign Edit   = edit_q;
   assign Cursor = cursor_q;
   assign Blank  = blank;
   assign Value  = value_q;
   assign Valid  = valid_q;

endmodule

// File: tb/tb_hex_entry_ctrl.sv
// Directed bench for hex_entry_ctrl with DEB_CYCLES=4, BLINK_BIT=3.
module tb_hex_entry_ctrl;

   logic        CLK;
   logic        Reset;
   logic [3:0]  btn;   // {CLR, OK, NEXT, INC}
   logic [15:0] Edit;
   logic [1:0]  Cursor;
   logic [3:0]  Blank;
   logic [15:0] Value;
   logic        Valid;

   int n_chk = 0;
   int n_err = 0;
   int valid_cnt = 0;
   bit valid_prev = 1'b0;
   bit valid_dbl = 1'b0;
   int v0;

   hex_entry_ctrl #(.DEB_CYCLES(4), .BLINK_BIT(3)) u_dut (
      .CLK      (CLK),
      .Reset    (Reset),
      .BTN_INC  (btn[0]),
      .BTN_NEXT (btn[1]),
      .BTN_OK   (btn[2]),
      .BTN_CLR  (btn[3]),
      .Edit     (Edit),
      .Cursor   (Cursor),
      .Blank    (Blank),
      .Value    (Value),
      .Valid    (Valid)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   always @(negedge CLK) begin
      if (Valid && valid_prev) valid_dbl = 1'b1;
      valid_prev = Valid;
      if (Valid) valid_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Raise the given buttons, hold through the action edge (8th edge after the
   // raise), then release and let the release debounce settle.
   task automatic press(input logic [3:0] mask);
      btn = mask;
      repeat (8) @(negedge CLK);
      btn = 4'b0000;
      repeat (12) @(negedge CLK);
   endtask

   initial begin
      btn   = 4'b0000;
      Reset = 1'b1;
      repeat (3) @(negedge CLK);
      check("rst_edit", 32'(Edit), 32'h0);
      check("rst_value", 32'(Value), 32'h0);
      check("rst_cursor", 32'(Cursor), 32'h0);
      check("rst_blank", 32'(Blank), 32'h0);
      check("rst_valid", 32'(Valid), 32'h0);
      Reset = 1'b0;
      repeat (2) @(negedge CLK);

      // Clean INC: raw sampled at edge k, action at edge k+7
      v0 = valid_cnt;
      btn = 4'b0001;
      for (int i = 0; i < 10; i++) begin
         @(negedge CLK);
         if (i == 6) check("lat_before", 32'(Edit), 32'h0000);
         if (i == 7) check("lat_at", 32'(Edit), 32'h0001);
      end
      btn = 4'b0000;
      repeat (12) @(negedge CLK);
      check("inc1_cursor", 32'(Cursor), 32'h0);
      check("inc1_novalid", 32'(valid_cnt - v0), 32'h0);

      // Walk digit 0 through F and back to 0
      for (int i = 2; i <= 16; i++) begin
         press(4'b0001);
         check("walk_edit", 32'(Edit), 32'(i % 16));
         check("walk_d1", 32'(Edit[7:4]), 32'h0);
      end

      // Cursor movement and per-digit increment
      press(4'b0010);
      check("next_cursor", 32'(Cursor), 32'h1);
      repeat (3) press(4'b0001);
      repeat (3) press(4'b0010);
      press(4'b0001);
      check("mix_edit", 32'(Edit), 32'h0031);
      check("mix_cursor", 32'(Cursor), 32'h0);
      press(4'b0010);
      check("wrap_cursor", 32'(Cursor), 32'h1);

      // Bounce: toggling every 2 cycles, then a 3-cycle glitch
      for (int i = 0; i < 5; i++) begin
         btn = 4'b0001;
         repeat (2) @(negedge CLK);
         btn = 4'b0000;
         repeat (2) @(negedge CLK);
      end
      repeat (10) @(negedge CLK);
      check("bounce_edit", 32'(Edit), 32'h0031);
      btn = 4'b0001;
      repeat (3) @(negedge CLK);
      btn = 4'b0000;
      repeat (10) @(negedge CLK);
      check("glitch_edit", 32'(Edit), 32'h0031);

      // CLR keeps Value, then build BEEF
      press(4'b1000);
      check("clr_edit", 32'(Edit), 32'h0);
      check("clr_cursor", 32'(Cursor), 32'h0);
      check("clr_value", 32'(Value), 32'h0);
      repeat (15) press(4'b0001);
      press(4'b0010);
      repeat (14) press(4'b0001);
      press(4'b0010);
      repeat (14) press(4'b0001);
      press(4'b0010);
      repeat (11) press(4'b0001);
      check("beef_edit", 32'(Edit), 32'hBEEF);
      check("beef_cursor", 32'(Cursor), 32'h3);

      v0 = valid_cnt;
      press(4'b0100);
      check("ok_value", 32'(Value), 32'hBEEF);
      check("ok_valid_cnt", 32'(valid_cnt - v0), 32'h1);
      check("ok_edit", 32'(Edit), 32'hBEEF);
      check("ok_cursor", 32'(Cursor), 32'h3);

      // Simultaneous events: CLR beats OK, INC beats NEXT
      v0 = valid_cnt;
      press(4'b1100);
      check("clrok_edit", 32'(Edit), 32'h0);
      check("clrok_cursor", 32'(Cursor), 32'h0);
      check("clrok_value", 32'(Value), 32'hBEEF);
      check("clrok_novalid", 32'(valid_cnt - v0), 32'h0);
      press(4'b0011);
      check("incnext_edit", 32'(Edit), 32'h0001);
      check("incnext_cursor", 32'(Cursor), 32'h0);

      // Blink on digit 2; counter is 12 when press() returns
      press(4'b0010);
      press(4'b0010);
      check("blink_cursor", 32'(Cursor), 32'h2);
      for (int i = 0; i < 32; i++) begin
         @(negedge CLK);
         check("blink", 32'(Blank), (((13 + i) / 8) % 2 == 1) ? 32'h4 : 32'h0);
      end
      btn = 4'b0001;
      repeat (8) @(negedge CLK);
      check("inc_blank_clr", 32'(Blank), 32'h0);
      check("inc_d2_edit", 32'(Edit), 32'h0101);
      btn = 4'b0000;
      repeat (12) @(negedge CLK);

      // Reset mid-debounce aborts the pending INC
      v0 = valid_cnt;
      btn = 4'b0001;
      repeat (3) @(negedge CLK);
      #2 Reset = 1'b1;
      @(negedge CLK);
      check("mrst_edit", 32'(Edit), 32'h0);
      check("mrst_value", 32'(Value), 32'h0);
      check("mrst_cursor", 32'(Cursor), 32'h0);
      check("mrst_blank", 32'(Blank), 32'h0);
      check("mrst_valid", 32'(Valid), 32'h0);
      btn = 4'b0000;
      repeat (2) @(negedge CLK);
      Reset = 1'b0;
      repeat (20) @(negedge CLK);
      check("mrst_noevent", 32'(Edit), 32'h0);
      check("mrst_novalid", 32'(valid_cnt - v0), 32'h0);
      check("valid_single", 32'(valid_dbl), 32'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
